// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the boot byte stream, load control/status and the
// instruction-memory write port of imem_loader.
//   master modport: byte source / host side (drives Start, WordCount, ByteIn, ByteValid).
//   slave modport:  the loader itself (drives ByteReady, Mem*, Busy, Done, Error, CpuHold).
// CNT_WIDTH must match the CNT_WIDTH of the connected imem_loader.
interface imem_loader_if #(
  parameter int unsigned CNT_WIDTH = 4
);
  logic                 Start;
  logic [CNT_WIDTH-1:0] WordCount;
  logic [7:0]           ByteIn;
  logic                 ByteValid;
  logic                 ByteReady;
  logic                 MemWE;
  logic [31:0]          MemAddress;
  logic [31:0]          MemWriteData;
  logic                 Busy;
  logic                 Done;
  logic                 Error;
  logic                 CpuHold;

  modport master (
    output Start, WordCount, ByteIn, ByteValid,
    input  ByteReady, MemWE, MemAddress, MemWriteData, Busy, Done, Error, CpuHold
  );

  modport slave (
    input  Start, WordCount, ByteIn, ByteValid,
    output ByteReady, MemWE, MemAddress, MemWriteData, Busy, Done, Error, CpuHold
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream over a valid/ready handshake, assembles
// little-endian 32-bit words and writes them to consecutive instruction-memory
// word addresses starting at 0. The processor is held (CpuHold) until a load
// completes without error.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - imem_loader_if.slave: Start/WordCount control, ByteIn/ByteValid/ByteReady
//              stream, MemWE/MemAddress/MemWriteData write port, Busy/Done/Error/CpuHold status
// All outputs are registered.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing byte equal to
// the XOR of all data bytes; a mismatch sets Error.
module imem_loader #(
  parameter int unsigned MEM_DEPTH = 8,
  parameter int unsigned CNT_WIDTH = 4
) (
  input logic         clk,
  input logic         reset_n,
  imem_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StCollect, StWrite, StDone, StCheck} state_e;
  logic [7:0] csum_q;
`else
  typedef enum logic [2:0] {StIdle, StCollect, StWrite, StDone} state_e;
`endif

  state_e               state_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] index_q;
  logic [1:0]           lane_q;
  logic                 byte_ready_q;
  logic                 mem_we_q;
  logic [31:0]          mem_addr_q;
  logic [31:0]          data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic                 cpu_hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      index_q      <= '0;
      lane_q       <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.Start) begin
            count_q <= bus.WordCount;
            index_q <= '0;
            lane_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
            if (bus.WordCount == '0) begin
              state_q    <= StDone;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else if (32'(bus.WordCount) > MEM_DEPTH) begin
              // Oversized load is rejected before any write; CPU stays held.
              state_q    <= StDone;
              done_q     <= 1'b1;
              error_q    <= 1'b1;
              cpu_hold_q <= 1'b1;
            end else begin
              state_q      <= StCollect;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
              cpu_hold_q   <= 1'b1;
            end
          end
        end

        StCollect: begin
          // byte_ready_q is always high here, so ByteValid alone marks a transfer.
          if (bus.ByteValid) begin
            data_q[{lane_q, 3'b000} +: 8] <= bus.ByteIn;
            lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.ByteIn;
`endif
            if (lane_q == 2'd3) begin
              state_q      <= StWrite;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_addr_q   <= 32'(index_q);
            end
          end
        end

        StWrite: begin
          mem_we_q <= 1'b0;
          index_q  <= index_q + CNT_WIDTH'(1);
          if (index_q == count_q - CNT_WIDTH'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q      <= StCheck;
            byte_ready_q <= 1'b1;
`else
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
`endif
          end else begin
            state_q      <= StCollect;
            byte_ready_q <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (bus.ByteValid) begin
            state_q      <= StDone;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            error_q      <= (bus.ByteIn != csum_q);
            cpu_hold_q   <= (bus.ByteIn != csum_q);
          end
        end
`endif

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ByteReady    = byte_ready_q;
  assign bus.MemWE        = mem_we_q;
  assign bus.MemAddress   = mem_addr_q;
  assign bus.MemWriteData = data_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Error        = error_q;
  assign bus.CpuHold      = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized loads checked by a write scoreboard
// (expected address/data pushed when a load is issued, popped by a monitor on
// every MemWE) plus directed reset, error and restart scenarios.
module tb_imem_loader;
  localparam int unsigned MEM_DEPTH = 8;
  localparam int unsigned CNT_WIDTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  imem_loader #(
    .MEM_DEPTH(MEM_DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int cyc = 0;
  int last_we = -100;
  int last_gap = 0;
  bit prev_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write the DUT issues must be the next expected one.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_we = 1'b0;
    end else begin
      if (bus.MemWE) begin
        if (exp_addr.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h with no write pending",
                   bus.MemAddress, bus.MemWriteData);
        end else begin
          check("write_addr", bus.MemAddress, exp_addr.pop_front());
          check("write_data", bus.MemWriteData, exp_data.pop_front());
        end
        check("we_single_cycle", 32'(prev_we), 32'd0);
        check("addr_in_range", 32'(bus.MemAddress < MEM_DEPTH), 32'd1);
        check("we_ready_exclusive", 32'(bus.ByteReady), 32'd0);
        last_gap = cyc - last_we;
        last_we  = cyc;
      end
      prev_we = bus.MemWE;
    end
  end

  task automatic start_load(input int count, input bit with_valid);
    @(negedge clk);
    bus.Start     = 1'b1;
    bus.WordCount = CNT_WIDTH'(count);
    bus.ByteValid = with_valid;
    bus.ByteIn    = 8'hA5;
    // A byte offered alongside Start must not be taken.
    check("ready_low_at_start", 32'(bus.ByteReady), 32'd0);
    @(negedge clk);
    bus.Start     = 1'b0;
    bus.ByteValid = 1'b0;
  endtask

  // mode 0: valid held high, 1: toggled, 2: random. noisy: spurious Start pulses.
  task automatic feed(input logic [7:0] data[$], input int mode, input bit noisy);
    int idx = 0;
    int n = 0;
    while (idx < data.size() && n < 400) begin
      bus.ByteIn = data[idx];
      case (mode)
        0:       bus.ByteValid = 1'b1;
        1:       bus.ByteValid = (n % 2 == 0);
        default: bus.ByteValid = 1'($urandom_range(0, 1));
      endcase
      if (noisy) begin
        bus.Start     = ($urandom_range(0, 3) == 0);
        bus.WordCount = CNT_WIDTH'($urandom);
      end
      if (bus.ByteValid && bus.ByteReady) idx++;
      n++;
      @(negedge clk);
    end
    bus.ByteValid = 1'b0;
    bus.Start     = 1'b0;
    check("bytes_accepted", 32'(idx), 32'(data.size()));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.Done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(bus.Done), 32'd1);
  endtask

  // Reference: word i is bytes 4i..4i+3, little-endian; error from oversize or bad checksum.
  task automatic run_load(input int count, input logic [7:0] data[$], input int mode,
                          input bit noisy, input bit with_valid, input logic [7:0] delta);
    logic [7:0] stream[$];
    logic [7:0] x;
    bit ok;
    bit err;
    x   = 8'h00;
    ok  = (count >= 1) && (count <= int'(MEM_DEPTH));
    err = (count > int'(MEM_DEPTH));
    if (ok) begin
      for (int i = 0; i < count; i++) begin
        exp_addr.push_back(32'(i));
        exp_data.push_back({data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]});
      end
      for (int i = 0; i < 4 * count; i++) begin
        x ^= data[i];
        stream.push_back(data[i]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(x ^ delta);
      if (delta != 8'h00) err = 1'b1;
`endif
    end
    start_load(count, with_valid);
    if (ok) begin
      check("busy_in_load", 32'(bus.Busy), 32'd1);
      check("done_cleared", 32'(bus.Done), 32'd0);
      check("hold_in_load", 32'(bus.CpuHold), 32'd1);
      check("error_cleared", 32'(bus.Error), 32'd0);
      feed(stream, mode, noisy);
    end
    wait_done();
    check("error_final", 32'(bus.Error), 32'(err));
    check("hold_final", 32'(bus.CpuHold), 32'(err));
    check("busy_final", 32'(bus.Busy), 32'd0);
    check("ready_final", 32'(bus.ByteReady), 32'd0);
    check("writes_all_seen", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(bus.MemWE), 32'd0);
    check({tag, "_ready"}, 32'(bus.ByteReady), 32'd0);
    check({tag, "_addr"}, bus.MemAddress, 32'd0);
    check({tag, "_data"}, bus.MemWriteData, 32'd0);
    check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    check({tag, "_done"}, 32'(bus.Done), 32'd0);
    check({tag, "_error"}, 32'(bus.Error), 32'd0);
    check({tag, "_hold"}, 32'(bus.CpuHold), 32'd1);
  endtask

  task automatic rand_bytes(input int count, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < 4 * count; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] d[$];
    int cnt;
    bus.Start     = 1'b0;
    bus.WordCount = '0;
    bus.ByteIn    = '0;
    bus.ByteValid = 1'b0;

    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Two words, valid held high: writes 5 cycles apart.
    d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(2, d, 0, 1'b0, 1'b0, 8'h00);
    check("write_gap", 32'(last_gap), 32'd5);

    // One word with toggling valid, Start accompanied by a byte.
    rand_bytes(1, d);
    run_load(1, d, 1, 1'b0, 1'b1, 8'h00);

    // Oversized and empty loads.
    d = {};
    run_load(9, d, 0, 1'b0, 1'b0, 8'h00);
    run_load(0, d, 0, 1'b0, 1'b0, 8'h00);

    // Spurious Start pulses while collecting.
    rand_bytes(3, d);
    run_load(3, d, 2, 1'b1, 1'b0, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    d = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_load(1, d, 0, 1'b0, 1'b0, 8'h00);
    run_load(1, d, 0, 1'b0, 1'b0, 8'h01);
`endif

    // Randomized loads.
    for (int t = 0; t < 10; t++) begin
      cnt = $urandom_range(0, 9);
      rand_bytes(cnt, d);
      run_load(cnt, d, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    end

    // Reset after 6 bytes of a 3-word load: only word 0 is written.
    rand_bytes(3, d);
    exp_addr.push_back(32'd0);
    exp_data.push_back({d[3], d[2], d[1], d[0]});
    start_load(3, 1'b0);
    d = d[0:5];
    feed(d, 0, 1'b0);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    check("mid_reset_writes", 32'(exp_addr.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset while the write strobe is up: it must drop at once.
    rand_bytes(2, d);
    exp_addr.push_back(32'd0);
    exp_data.push_back({d[3], d[2], d[1], d[0]});
    start_load(2, 1'b0);
    d = d[0:3];
    feed(d, 0, 1'b0);
    check("we_before_reset", 32'(bus.MemWE), 32'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("we_reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Normal load after a reset.
    rand_bytes(2, d);
    run_load(2, d, 0, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", nerr);
    $fatal(1);
  end

endmodule
